// File: rtl/post_slowdown_ctrl_if.sv
// Bundle between the POST sequencer and its surroundings: raw CPU-side
// inputs in, injector request level and status out.
interface post_slowdown_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             post_bit;
  logic             cpu_rst_n;
  logic             i2c_send;
  logic [CNT_W-1:0] post_cnt;
  logic [2:0]       state_o;
  logic             aborted;

  modport master (output post_bit, cpu_rst_n, input i2c_send, post_cnt, state_o, aborted);
  modport slave  (input post_bit, cpu_rst_n, output i2c_send, post_cnt, state_o, aborted);
endinterface

// File: rtl/post_slowdown_ctrl.sv
// Counts debounced POST-bit toggles and raises/drops the injector's i2c_send
// level at configured counts; a watchdog aborts to speedup if POST stalls.
module post_slowdown_ctrl #(
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 4,
  parameter int SLOW_AT     = 2,
  parameter int FAST_AT     = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input logic                clk,
  input logic                rst,
  post_slowdown_ctrl_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_SLOW  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  logic [1:0]       post_sync, rstn_sync;
  logic             post_s, rstn_s;
  logic             filt_lvl;
  logic [3:0]       filt_cnt;
  logic             evt;
  logic [17:0]      timer;
  logic [2:0]       state;
  logic             i2c_q;
  logic             abort_q;
  logic [CNT_W-1:0] cnt, cnt_inc;

  assign post_s  = post_sync[1];
  assign rstn_s  = rstn_sync[1];
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  // Synchronisers and debounce filter run regardless of sequencer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      post_sync <= '0;
      rstn_sync <= '0;
      filt_lvl  <= 1'b0;
      filt_cnt  <= '0;
      evt       <= 1'b0;
    end else begin
      post_sync <= {post_sync[0], bus.post_bit};
      rstn_sync <= {rstn_sync[0], bus.cpu_rst_n};
      evt       <= 1'b0;
      if (post_s != filt_lvl) begin
        if (filt_cnt == 4'(FILT_LEN - 1)) begin
          filt_lvl <= post_s;
          filt_cnt <= '0;
          evt      <= 1'b1;
        end else begin
          filt_cnt <= filt_cnt + 4'd1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // CPU reset outranks events and the watchdog in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      timer   <= '0;
      i2c_q   <= 1'b0;
      abort_q <= 1'b0;
    end else if (!rstn_s) begin
      state   <= S_IDLE;
      cnt     <= '0;
      timer   <= '0;
      i2c_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_COUNT;
          timer <= '0;
          i2c_q <= 1'b0;
        end
        S_COUNT, S_SLOW: begin
          if (evt) begin
            cnt   <= cnt_inc;
            timer <= '0;
            if (state == S_COUNT && cnt_inc == CNT_W'(SLOW_AT)) begin
              state <= S_SLOW;
              i2c_q <= 1'b1;
            end else if (state == S_SLOW && cnt_inc == CNT_W'(FAST_AT)) begin
              state <= S_DONE;
              i2c_q <= 1'b0;
            end
          end else if (timer == 18'(TIMEOUT_CYC - 1)) begin
            state   <= S_ABORT;
            timer   <= '0;
            i2c_q   <= 1'b0;
            abort_q <= 1'b1;
          end else begin
            timer <= timer + 18'd1;
          end
        end
        S_DONE: begin
          i2c_q <= 1'b0;
          if (evt) cnt <= cnt_inc;
        end
        S_ABORT: begin
          i2c_q   <= 1'b0;
          abort_q <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          i2c_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.i2c_send = i2c_q;
  assign bus.post_cnt = cnt;
  assign bus.state_o  = state;
  assign bus.aborted  = abort_q;
endmodule

// File: tb/tb_post_slowdown_ctrl.sv
// Scenario bench for post_slowdown_ctrl; expectations come from event counts
// and edge timing derived from the sequencing rules, not from the RTL.
module tb_post_slowdown_ctrl;
  localparam int FL  = 4;
  localparam int TO  = 100;
  localparam int LAT = FL + 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  post_slowdown_ctrl_if #(.CNT_W(4)) ifa ();
  post_slowdown_ctrl_if #(.CNT_W(2)) ifb ();

  post_slowdown_ctrl #(.FILT_LEN(FL), .CNT_W(4), .SLOW_AT(2), .FAST_AT(4), .TIMEOUT_CYC(TO))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  post_slowdown_ctrl #(.FILT_LEN(FL), .CNT_W(2), .SLOW_AT(2), .FAST_AT(3), .TIMEOUT_CYC(TO))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // State reached after k accepted events, starting from COUNT with post_cnt 0.
  function automatic int exp_state(input int k, input int slow, input int fast);
    return (k < slow) ? 1 : (k < fast) ? 2 : 3;
  endfunction

  function automatic int sat(input int k, input int mx);
    return (k > mx) ? mx : k;
  endfunction

  task automatic rearm_a();
    ifa.cpu_rst_n = 1'b0; step(3);
    ifa.cpu_rst_n = 1'b1; step(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.post_bit = 1'b0; ifa.cpu_rst_n = 1'b0;
    ifb.post_bit = 1'b0; ifb.cpu_rst_n = 1'b0;
    step(2);
    checks++; if (ifa.state_o !== 3'd0) begin errors++; $display("FAIL reset_state_a got %0d want 0", ifa.state_o); end
    checks++; if (ifa.i2c_send !== 1'b0) begin errors++; $display("FAIL reset_i2c_a got %b want 0", ifa.i2c_send); end
    checks++; if (ifa.post_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt_a got %0d want 0", ifa.post_cnt); end
    checks++; if (ifa.aborted !== 1'b0) begin errors++; $display("FAIL reset_abort_a got %b want 0", ifa.aborted); end
    checks++; if (ifb.state_o !== 3'd0 || ifb.post_cnt !== 2'd0 || ifb.i2c_send !== 1'b0)
      begin errors++; $display("FAIL reset_b got st=%0d cnt=%0d i2c=%b want 0/0/0", ifb.state_o, ifb.post_cnt, ifb.i2c_send); end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_nominal();
    ifa.cpu_rst_n = 1'b1;
    step(2);
    checks++; if (ifa.state_o !== 3'd0) begin errors++; $display("FAIL nom_idle got %0d want 0", ifa.state_o); end
    step(1);
    checks++; if (ifa.state_o !== 3'd1) begin errors++; $display("FAIL nom_count got %0d want 1", ifa.state_o); end
    for (int k = 1; k <= 4; k++) begin
      ifa.post_bit = ~ifa.post_bit;
      step(LAT - 1);
      checks++; if (ifa.post_cnt !== 4'(k - 1) || ifa.i2c_send !== (exp_state(k - 1, 2, 4) == 2))
        begin errors++; $display("FAIL nom_pre%0d got cnt=%0d i2c=%b want cnt=%0d", k, ifa.post_cnt, ifa.i2c_send, k - 1); end
      step(1);
      checks++; if (ifa.post_cnt !== 4'(k) || ifa.state_o !== 3'(exp_state(k, 2, 4)) || ifa.i2c_send !== (exp_state(k, 2, 4) == 2))
        begin errors++; $display("FAIL nom_post%0d got cnt=%0d st=%0d i2c=%b want cnt=%0d st=%0d", k, ifa.post_cnt, ifa.state_o, ifa.i2c_send, k, exp_state(k, 2, 4)); end
      step(20 - LAT);
    end
  endtask

  task automatic test_glitch();
    rearm_a();
    for (int i = 0; i < 3; i++) begin
      ifa.post_bit = ~ifa.post_bit; step($urandom_range(1, FL - 1));
      ifa.post_bit = ~ifa.post_bit; step(12);
    end
    checks++; if (ifa.post_cnt !== 4'd0 || ifa.i2c_send !== 1'b0 || ifa.state_o !== 3'd1)
      begin errors++; $display("FAIL glitch_reject got cnt=%0d i2c=%b st=%0d want 0/0/1", ifa.post_cnt, ifa.i2c_send, ifa.state_o); end
    ifa.post_bit = ~ifa.post_bit; step(FL);
    ifa.post_bit = ~ifa.post_bit; step(12);
    checks++; if (ifa.post_cnt !== 4'd2 || ifa.i2c_send !== 1'b1 || ifa.state_o !== 3'd2)
      begin errors++; $display("FAIL glitch_accept got cnt=%0d i2c=%b st=%0d want 2/1/2", ifa.post_cnt, ifa.i2c_send, ifa.state_o); end
  endtask

  task automatic test_watchdog();
    ifa.post_bit = ~ifa.post_bit;
    step(LAT);
    checks++; if (ifa.post_cnt !== 4'd3 || ifa.state_o !== 3'd2)
      begin errors++; $display("FAIL wd_setup got cnt=%0d st=%0d want 3/2", ifa.post_cnt, ifa.state_o); end
    step(TO - 1);
    checks++; if (ifa.state_o !== 3'd2) begin errors++; $display("FAIL wd_early got st=%0d want 2", ifa.state_o); end
    step(1);
    checks++; if (ifa.state_o !== 3'd4 || ifa.i2c_send !== 1'b0 || ifa.aborted !== 1'b1)
      begin errors++; $display("FAIL wd_abort got st=%0d i2c=%b ab=%b want 4/0/1", ifa.state_o, ifa.i2c_send, ifa.aborted); end
    for (int i = 0; i < 2; i++) begin ifa.post_bit = ~ifa.post_bit; step(15); end
    checks++; if (ifa.state_o !== 3'd4 || ifa.post_cnt !== 4'd3 || ifa.aborted !== 1'b1)
      begin errors++; $display("FAIL wd_ignore got st=%0d cnt=%0d ab=%b want 4/3/1", ifa.state_o, ifa.post_cnt, ifa.aborted); end
  endtask

  task automatic test_coincidence();
    ifa.cpu_rst_n = 1'b0; step(3);
    checks++; if (ifa.state_o !== 3'd0 || ifa.aborted !== 1'b0 || ifa.post_cnt !== 4'd0)
      begin errors++; $display("FAIL cpurst_clear got st=%0d ab=%b cnt=%0d want 0/0/0", ifa.state_o, ifa.aborted, ifa.post_cnt); end
    ifa.cpu_rst_n = 1'b1;
    step(TO - FL);
    ifa.post_bit = ~ifa.post_bit;
    step(LAT - 1);
    checks++; if (ifa.state_o !== 3'd1 || ifa.post_cnt !== 4'd0)
      begin errors++; $display("FAIL coin_pre got st=%0d cnt=%0d want 1/0", ifa.state_o, ifa.post_cnt); end
    step(1);
    checks++; if (ifa.state_o !== 3'd1 || ifa.post_cnt !== 4'd1 || ifa.aborted !== 1'b0)
      begin errors++; $display("FAIL coin_event got st=%0d cnt=%0d ab=%b want 1/1/0", ifa.state_o, ifa.post_cnt, ifa.aborted); end
    step(TO - 1);
    checks++; if (ifa.state_o !== 3'd1) begin errors++; $display("FAIL coin_timer_clr got st=%0d want 1", ifa.state_o); end
    step(1);
    checks++; if (ifa.state_o !== 3'd4) begin errors++; $display("FAIL coin_re_abort got st=%0d want 4", ifa.state_o); end
  endtask

  task automatic test_cpu_reset_slow();
    rearm_a();
    for (int i = 0; i < 2; i++) begin ifa.post_bit = ~ifa.post_bit; step(15); end
    checks++; if (ifa.state_o !== 3'd2 || ifa.i2c_send !== 1'b1)
      begin errors++; $display("FAIL cr_slow got st=%0d i2c=%b want 2/1", ifa.state_o, ifa.i2c_send); end
    ifa.cpu_rst_n = 1'b0;
    step(2);
    checks++; if (ifa.i2c_send !== 1'b1) begin errors++; $display("FAIL cr_early got i2c=%b want 1", ifa.i2c_send); end
    step(1);
    checks++; if (ifa.i2c_send !== 1'b0 || ifa.state_o !== 3'd0 || ifa.post_cnt !== 4'd0)
      begin errors++; $display("FAIL cr_drop got i2c=%b st=%0d cnt=%0d want 0/0/0", ifa.i2c_send, ifa.state_o, ifa.post_cnt); end
    ifa.cpu_rst_n = 1'b1;
    step(3);
    for (int k = 1; k <= 4; k++) begin
      ifa.post_bit = ~ifa.post_bit;
      step(LAT - 1);
      checks++; if (ifa.post_cnt !== 4'(k - 1))
        begin errors++; $display("FAIL replay_pre%0d got cnt=%0d want %0d", k, ifa.post_cnt, k - 1); end
      step(1);
      checks++; if (ifa.post_cnt !== 4'(k) || ifa.state_o !== 3'(exp_state(k, 2, 4)) || ifa.i2c_send !== (exp_state(k, 2, 4) == 2))
        begin errors++; $display("FAIL replay_post%0d got cnt=%0d st=%0d i2c=%b want cnt=%0d st=%0d", k, ifa.post_cnt, ifa.state_o, ifa.i2c_send, k, exp_state(k, 2, 4)); end
      step(20 - LAT);
    end
  endtask

  task automatic test_random();
    int k = 0;
    rearm_a();
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ifa.post_bit = ~ifa.post_bit; step($urandom_range(1, FL - 1));
        ifa.post_bit = ~ifa.post_bit; step(FL + 4);
        checks++; if (ifa.post_cnt !== 4'(sat(k, 15)) || ifa.state_o !== 3'(exp_state(k, 2, 4)))
          begin errors++; $display("FAIL rnd_glitch%0d got cnt=%0d st=%0d want cnt=%0d", n, ifa.post_cnt, ifa.state_o, sat(k, 15)); end
      end
      ifa.post_bit = ~ifa.post_bit;
      step(LAT - 1);
      checks++; if (ifa.post_cnt !== 4'(sat(k, 15)))
        begin errors++; $display("FAIL rnd_pre%0d got cnt=%0d want %0d", n, ifa.post_cnt, sat(k, 15)); end
      step(1);
      k++;
      checks++; if (ifa.post_cnt !== 4'(sat(k, 15)) || ifa.state_o !== 3'(exp_state(k, 2, 4)) || ifa.i2c_send !== (exp_state(k, 2, 4) == 2))
        begin errors++; $display("FAIL rnd_post%0d got cnt=%0d st=%0d i2c=%b want cnt=%0d st=%0d", n, ifa.post_cnt, ifa.state_o, ifa.i2c_send, sat(k, 15), exp_state(k, 2, 4)); end
      step($urandom_range(0, 20));
    end
  endtask

  task automatic test_saturation();
    ifb.cpu_rst_n = 1'b1;
    step(3);
    checks++; if (ifb.state_o !== 3'd1) begin errors++; $display("FAIL sat_arm got st=%0d want 1", ifb.state_o); end
    for (int k = 1; k <= 6; k++) begin
      ifb.post_bit = ~ifb.post_bit;
      step(LAT);
      checks++; if (ifb.post_cnt !== 2'(sat(k, 3)) || ifb.state_o !== 3'(exp_state(k, 2, 3)) || ifb.i2c_send !== (exp_state(k, 2, 3) == 2))
        begin errors++; $display("FAIL sat_%0d got cnt=%0d st=%0d i2c=%b want cnt=%0d st=%0d", k, ifb.post_cnt, ifb.state_o, ifb.i2c_send, sat(k, 3), exp_state(k, 2, 3)); end
      step(5);
    end
    rst = 1'b1;
    step(1);
    checks++; if (ifb.post_cnt !== 2'd0 || ifb.state_o !== 3'd0 || ifb.i2c_send !== 1'b0 || ifb.aborted !== 1'b0)
      begin errors++; $display("FAIL rst_mid_b got cnt=%0d st=%0d i2c=%b ab=%b want 0", ifb.post_cnt, ifb.state_o, ifb.i2c_send, ifb.aborted); end
    checks++; if (ifa.post_cnt !== 4'd0 || ifa.state_o !== 3'd0 || ifa.i2c_send !== 1'b0 || ifa.aborted !== 1'b0)
      begin errors++; $display("FAIL rst_mid_a got cnt=%0d st=%0d i2c=%b ab=%b want 0", ifa.post_cnt, ifa.state_o, ifa.i2c_send, ifa.aborted); end
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_watchdog();
    test_coincidence();
    test_cpu_reset_slow();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
